// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and alignment rule for the memory access unit.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Size code 3 behaves as a word access.
    function automatic logic align_ok(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return 1'b1;
            SZ_H:    return ~addr_lo[0];
            default: return (addr_lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: selects the addressed byte/half lane and extends it to 32 bits.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata_i[{off_i, 3'b000} +: 8];
        lane_h = rdata_i[{off_i[1], 4'b0000} +: 16];
        case (size_i)
            SZ_B:    data_o = {{24{signed_i & lane_b[7]}}, lane_b};
            SZ_H:    data_o = {{16{signed_i & lane_h[15]}}, lane_h};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: sized stores with byte strobes, alignment exceptions,
// and loads against an SRAM of configurable read latency with pipeline stall.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              flush,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              adel,
    output logic              ades,
    output logic [ADDR_W-1:0] badvaddr,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       off_q, off_d;
    logic [1:0]       size_q, size_d;
    logic             signed_q, signed_d;

    logic [31:0]       load_data;
    logic [1:0]        addr_lo;
    logic              aligned;
    logic [ADDR_W-1:0] word_addr;

    load_align u_load_align (
        .rdata_i  (sram_rdata),
        .off_i    (off_q),
        .size_i   (size_q),
        .signed_i (signed_q),
        .data_o   (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            off_q    <= '0;
            size_q   <= SZ_W;
            signed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            off_q    <= off_d;
            size_q   <= size_d;
            signed_q <= signed_d;
        end
    end

    // Next state and the same-cycle response / SRAM control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        off_d      = off_q;
        size_d     = size_q;
        signed_d   = signed_q;
        stall      = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        adel       = 1'b0;
        ades       = 1'b0;
        badvaddr   = '0;
        sram_en    = 1'b0;
        sram_wen   = '0;
        sram_addr  = '0;
        sram_wdata = '0;

        addr_lo   = req_addr[1:0];
        aligned   = align_ok(req_size, addr_lo);
        word_addr = {req_addr[ADDR_W-1:2], 2'b00};

        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    if (!aligned) begin
                        resp_valid = 1'b1;
                        adel       = ~req_we;
                        ades       = req_we;
                        badvaddr   = req_addr;
                    end else if (req_we) begin
                        sram_en    = 1'b1;
                        sram_addr  = word_addr;
                        resp_valid = 1'b1;
                        case (req_size)
                            SZ_B: begin
                                sram_wen   = 4'b0001 << addr_lo;
                                sram_wdata = {4{req_wdata[7:0]}};
                            end
                            SZ_H: begin
                                sram_wen   = 4'b0011 << addr_lo;
                                sram_wdata = {2{req_wdata[15:0]}};
                            end
                            default: begin
                                sram_wen   = 4'b1111;
                                sram_wdata = req_wdata;
                            end
                        endcase
                    end else begin
                        sram_en   = 1'b1;
                        sram_addr = word_addr;
                        stall     = 1'b1;
                        off_d     = addr_lo;
                        size_d    = req_size;
                        signed_d  = req_signed;
                        cnt_d     = CNT_W'(RD_LAT - 1);
                        state_d   = (RD_LAT > 1) ? WAIT : RESP;
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                if (!flush) begin
                    resp_valid = 1'b1;
                    resp_rdata = load_data;
                end
            end
            default: state_d = IDLE;
        endcase

        // No SRAM activity or response may escape while reset is held.
        if (rst) begin
            stall      = 1'b0;
            resp_valid = 1'b0;
            resp_rdata = '0;
            adel       = 1'b0;
            ades       = 1'b0;
            badvaddr   = '0;
            sram_en    = 1'b0;
            sram_wen   = '0;
            sram_addr  = '0;
            sram_wdata = '0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit at read latencies 1, 3 and 4.
module tb_mem_access_unit;
    import mem_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic        chk_rdata;
        logic        adel;
        logic        ades;
        logic [31:0] badvaddr;
    } resp_t;

    localparam int unsigned ND = 3;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [ND];
    logic        req_valid  [ND];
    logic        req_we     [ND];
    logic [1:0]  req_size   [ND];
    logic        req_signed [ND];
    logic [31:0] req_addr   [ND];
    logic [31:0] req_wdata  [ND];
    logic        flush      [ND];
    logic        stall      [ND];
    logic        resp_valid [ND];
    logic [31:0] resp_rdata [ND];
    logic        adel       [ND];
    logic        ades       [ND];
    logic [31:0] badvaddr   [ND];
    logic        sram_en    [ND];
    logic [3:0]  sram_wen   [ND];
    logic [31:0] sram_addr  [ND];
    logic [31:0] sram_wdata [ND];
    logic [31:0] sram_rdata [ND];

    resp_t exp_q [ND][$];
    int pass_cnt  = 0;
    int total_cnt = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        mem_access_unit #(
            .ADDR_W (32),
            .RD_LAT ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req_valid  (req_valid[g]),
            .req_we     (req_we[g]),
            .req_size   (req_size[g]),
            .req_signed (req_signed[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .flush      (flush[g]),
            .stall      (stall[g]),
            .resp_valid (resp_valid[g]),
            .resp_rdata (resp_rdata[g]),
            .adel       (adel[g]),
            .ades       (ades[g]),
            .badvaddr   (badvaddr[g]),
            .sram_en    (sram_en[g]),
            .sram_wen   (sram_wen[g]),
            .sram_addr  (sram_addr[g]),
            .sram_wdata (sram_wdata[g]),
            .sram_rdata (sram_rdata[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Response monitor: every resp_valid must match the oldest expected response.
    for (genvar g = 0; g < ND; g++) begin : g_mon
        always @(negedge clk) begin
            resp_t e;
            if (resp_valid[g] === 1'b1) begin
                if (exp_q[g].size() == 0) begin
                    chk($sformatf("dut%0d unexpected resp_valid", g), 32'(1), 32'(0));
                end else begin
                    e = exp_q[g].pop_front();
                    chk($sformatf("dut%0d resp adel", g), 32'(adel[g]), 32'(e.adel));
                    chk($sformatf("dut%0d resp ades", g), 32'(ades[g]), 32'(e.ades));
                    if (e.adel || e.ades)
                        chk($sformatf("dut%0d resp badvaddr", g), badvaddr[g], e.badvaddr);
                    if (e.chk_rdata)
                        chk($sformatf("dut%0d resp rdata", g), resp_rdata[g], e.rdata);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs(input int d);
        req_valid[d]  = 1'b0;
        req_we[d]     = 1'b0;
        req_size[d]   = SZ_W;
        req_signed[d] = 1'b0;
        req_addr[d]   = '0;
        req_wdata[d]  = '0;
        flush[d]      = 1'b0;
    endtask

    task automatic issue(input int d, input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_size[d]   = sz;
        req_signed[d] = sgn;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
    endtask

    task automatic expect_resp(input int d, input logic [31:0] rdata, input logic chk_rd,
                               input logic ae_l, input logic ae_s, input logic [31:0] bad);
        resp_t e;
        e.rdata     = rdata;
        e.chk_rdata = chk_rd;
        e.adel      = ae_l;
        e.ades      = ae_s;
        e.badvaddr  = bad;
        exp_q[d].push_back(e);
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            idle_inputs(d);
            rst[d]        = 1'b1;
            sram_rdata[d] = JUNK;
        end

        // Store held during reset must not reach the SRAM.
        issue(0, 1'b1, SZ_W, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF);
        mid();
        chk("rst sram_en", 32'(sram_en[0]), 32'(0));
        chk("rst sram_wen", 32'(sram_wen[0]), 32'(0));
        chk("rst resp_valid", 32'(resp_valid[0]), 32'(0));
        chk("rst stall", 32'(stall[0]), 32'(0));
        step();
        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b0;
            idle_inputs(d);
        end
        step();

        // sb 0x1003 at latency 1: same-cycle completion.
        issue(0, 1'b1, SZ_B, 1'b0, 32'h0000_1003, 32'h0000_00A5);
        expect_resp(0, '0, 1'b0, 1'b0, 1'b0, '0);
        mid();
        chk("sb sram_en", 32'(sram_en[0]), 32'(1));
        chk("sb sram_wen", 32'(sram_wen[0]), 32'(4'b1000));
        chk("sb sram_wdata", sram_wdata[0], 32'hA5A5_A5A5);
        chk("sb sram_addr", sram_addr[0], 32'h0000_1000);
        chk("sb stall", 32'(stall[0]), 32'(0));
        step();
        idle_inputs(0);

        // lh signed 0x2002 at latency 3; request held by the stalled stage.
        issue(1, 1'b0, SZ_H, 1'b1, 32'h0000_2002, '0);
        expect_resp(1, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0, '0);
        mid();
        chk("lh T stall", 32'(stall[1]), 32'(1));
        chk("lh T sram_en", 32'(sram_en[1]), 32'(1));
        chk("lh T sram_wen", 32'(sram_wen[1]), 32'(0));
        chk("lh T sram_addr", sram_addr[1], 32'h0000_2000);
        step();
        mid();
        chk("lh T+1 stall", 32'(stall[1]), 32'(1));
        chk("lh T+1 sram_en", 32'(sram_en[1]), 32'(0));
        step();
        mid();
        chk("lh T+2 stall", 32'(stall[1]), 32'(1));
        chk("lh T+2 resp_valid", 32'(resp_valid[1]), 32'(0));
        step();
        sram_rdata[1] = 32'h8001_1234;
        mid();
        chk("lh T+3 resp_valid", 32'(resp_valid[1]), 32'(1));
        chk("lh T+3 stall", 32'(stall[1]), 32'(0));
        step();
        idle_inputs(1);
        sram_rdata[1] = JUNK;
        mid();
        chk("lh T+4 resp_valid", 32'(resp_valid[1]), 32'(0));
        step();

        // lbu 0x2001 at latency 1.
        issue(0, 1'b0, SZ_B, 1'b0, 32'h0000_2001, '0);
        expect_resp(0, 32'h0000_00F6, 1'b1, 1'b0, 1'b0, '0);
        mid();
        chk("lbu T stall", 32'(stall[0]), 32'(1));
        step();
        sram_rdata[0] = 32'h1234_F6AB;
        mid();
        chk("lbu T+1 stall", 32'(stall[0]), 32'(0));
        step();
        idle_inputs(0);
        sram_rdata[0] = JUNK;

        // lb signed 0x6003 at latency 1.
        issue(0, 1'b0, SZ_B, 1'b1, 32'h0000_6003, '0);
        expect_resp(0, 32'hFFFF_FF85, 1'b1, 1'b0, 1'b0, '0);
        step();
        sram_rdata[0] = 32'h8512_3456;
        step();
        idle_inputs(0);
        sram_rdata[0] = JUNK;

        // Misaligned lw and sh.
        issue(0, 1'b0, SZ_W, 1'b0, 32'h0000_3002, '0);
        expect_resp(0, '0, 1'b0, 1'b1, 1'b0, 32'h0000_3002);
        mid();
        chk("adel sram_en", 32'(sram_en[0]), 32'(0));
        chk("adel stall", 32'(stall[0]), 32'(0));
        step();
        issue(0, 1'b1, SZ_H, 1'b0, 32'h0000_3001, 32'h0000_BEEF);
        expect_resp(0, '0, 1'b0, 1'b0, 1'b1, 32'h0000_3001);
        mid();
        chk("ades sram_wen", 32'(sram_wen[0]), 32'(0));
        chk("ades sram_en", 32'(sram_en[0]), 32'(0));
        step();

        // Flush in IDLE blocks acceptance.
        issue(0, 1'b1, SZ_W, 1'b0, 32'h0000_0020, 32'h1234_5678);
        flush[0] = 1'b1;
        mid();
        chk("idle flush sram_en", 32'(sram_en[0]), 32'(0));
        chk("idle flush resp_valid", 32'(resp_valid[0]), 32'(0));
        step();
        idle_inputs(0);

        // Latency 4: flush at T+2, new load accepted at T+3, stale data at T+4 ignored.
        issue(2, 1'b0, SZ_W, 1'b0, 32'h0000_4000, '0);
        mid();
        chk("fl T stall", 32'(stall[2]), 32'(1));
        step();
        step();
        flush[2] = 1'b1;
        mid();
        chk("fl T+2 stall", 32'(stall[2]), 32'(0));
        chk("fl T+2 resp_valid", 32'(resp_valid[2]), 32'(0));
        step();
        flush[2] = 1'b0;
        issue(2, 1'b0, SZ_W, 1'b0, 32'h0000_4008, '0);
        expect_resp(2, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, '0);
        mid();
        chk("fl T+3 sram_en", 32'(sram_en[2]), 32'(1));
        chk("fl T+3 sram_addr", sram_addr[2], 32'h0000_4008);
        chk("fl T+3 stall", 32'(stall[2]), 32'(1));
        step();
        sram_rdata[2] = 32'h0BAD_BAD0;
        mid();
        chk("fl T+4 resp_valid", 32'(resp_valid[2]), 32'(0));
        step();
        sram_rdata[2] = JUNK;
        mid();
        chk("fl T+5 resp_valid", 32'(resp_valid[2]), 32'(0));
        step();
        step();
        sram_rdata[2] = 32'hCAFE_F00D;
        mid();
        chk("fl T+7 resp_valid", 32'(resp_valid[2]), 32'(1));
        step();
        idle_inputs(2);
        sram_rdata[2] = JUNK;

        // Reset while waiting at latency 3.
        issue(1, 1'b0, SZ_W, 1'b0, 32'h0000_5000, '0);
        mid();
        chk("rw T stall", 32'(stall[1]), 32'(1));
        step();
        rst[1] = 1'b1;
        idle_inputs(1);
        mid();
        chk("rw T+1 stall", 32'(stall[1]), 32'(0));
        step();
        rst[1] = 1'b0;
        issue(1, 1'b1, SZ_B, 1'b0, 32'h0000_5001, 32'h0000_007E);
        expect_resp(1, '0, 1'b0, 1'b0, 1'b0, '0);
        mid();
        chk("rw T+2 stall", 32'(stall[1]), 32'(0));
        chk("rw T+2 sram_wen", 32'(sram_wen[1]), 32'(4'b0010));
        chk("rw T+2 sram_wdata", sram_wdata[1], 32'h7E7E_7E7E);
        step();
        idle_inputs(1);

        repeat (6) step();
        for (int d = 0; d < ND; d++)
            chk($sformatf("dut%0d pending responses", d), 32'(exp_q[d].size()), 32'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised load/store unit between the MIPS MEM stage and a synchronous data SRAM. It replaces the fixed single-cycle memwrite/wea path with:
- byte/halfword/word access and per-lane write strobes;
- sign/zero load extension and alignment exception detection;
- a configurable SRAM read latency, with a pipeline stall while a load is outstanding.

## Interface
Parameters:
- ADDR_W, 32, address width (≥3)
- RD_LAT, 1, SRAM read latency in cycles from enable to data, legal 1..7

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  MEM stage presents an access
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word (3 treated as word)
- req_signed  in  1  loads: sign-extend when 1
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- flush  in  1  cancel current/outstanding access (exception/branch flush)
- stall  out  1  hold MEM stage and all earlier stages
- resp_valid  out  1  access completes this cycle
- resp_rdata  out  32  extended load data, valid with resp_valid on loads
- adel  out  1  misaligned load, valid with resp_valid
- ades  out  1  misaligned store, valid with resp_valid
- badvaddr  out  ADDR_W  faulting address, valid when adel|ades
- sram_en  out  1  SRAM access enable
- sram_wen  out  4  byte write strobes, lane k = bits 8k+7:8k
- sram_addr  out  ADDR_W  word-aligned address, req_addr with low 2 bits forced to 0
- sram_wdata  out  32  lane-replicated store data
- sram_rdata  in  32  read data, valid RD_LAT cycles after sram_en

## Operation
- FSM states: IDLE, WAIT, RESP. Reset → IDLE, latency counter 0.
- Alignment:
  - half requires addr[0]=0;
  - word requires addr[1:0]=0;
  - byte is always aligned.
- IDLE, req_valid=1, flush=0 (accept):
  - Misaligned: no SRAM access. resp_valid=1 with adel (load) or ades (store), badvaddr=req_addr, stall=0. Stay IDLE.
  - Aligned store: sram_en=1, resp_valid=1, stall=0. Stay IDLE.
    - byte: sram_wen=4'b0001<<off, sram_wdata={4{wdata[7:0]}}
    - half: sram_wen=4'b0011<<off, sram_wdata={2{wdata[15:0]}}
    - word: sram_wen=4'b1111, sram_wdata=wdata
  - Aligned load: sram_en=1, sram_wen=0, stall=1. Latch off=addr[1:0], size, signed. Counter←RD_LAT-1. Go to WAIT if RD_LAT>1, else RESP.
- WAIT:
  - stall=1, sram_en=0, inputs ignored.
  - Counter decrements each cycle; at 1, go to RESP.
- RESP:
  - sram_rdata is valid this cycle; resp_valid=1, stall=0, resp_rdata formatted from latched fields.
  - Load formatting:
    - byte = rdata[8·off+:8]
    - half = rdata[16·off[1]+:16]
    - extended by the latched signed bit
  - req_valid is ignored (it is still the same load). Next state is IDLE.
- flush:
  - IDLE: no acceptance, sram_en=0, resp_valid=0.
  - WAIT or RESP: go to IDLE next cycle, resp_valid=0, stall=0 in that cycle, late SRAM data discarded.
- Little-endian lane mapping throughout.

## Timing
- Store and misaligned access: 0-cycle, fully combinational response, no stall.
- Aligned load accepted in cycle T:
  - stall=1 in cycles T..T+RD_LAT-1;
  - resp_valid=1 at T+RD_LAT;
  - earliest next acceptance is T+RD_LAT+1.
- All outputs are forced to 0 while rst=1, including sram_en, so no SRAM write occurs during reset.
- rst during WAIT/RESP: IDLE next cycle, no resp_valid for the aborted load.
- flush and rst may coincide; rst dominates, with identical outcome.

## Structure
- Package mem_pkg holds:
  - size encodings SZ_B=2'd0, SZ_H=2'd1, SZ_W=2'd2;
  - state enum {IDLE, WAIT, RESP};
  - function align_ok(size, addr_lo).
- Sub-module load_align: combinational (rdata, off, size, signed) → resp_rdata; reused by future cache refill path.
- Counter width $clog2(RD_LAT+1).

## Test plan
- RD_LAT=1, sb addr 0x1003, wdata 0x000000A5 → same cycle sram_en=1, sram_wen=4'b1000, sram_wdata=0xA5A5A5A5, sram_addr=0x1000, resp_valid=1, stall=0.
- RD_LAT=3, lh signed addr 0x2002, sram_rdata=0x8001_1234 at T+3 → stall=1 T..T+2, resp_valid at T+3, resp_rdata=0xFFFF8001.
- RD_LAT=1, lbu addr 0x2001, sram_rdata=0x1234_F6AB → resp_rdata=0x000000F6 at T+1.
- lw addr 0x3002 → resp_valid=1, adel=1, badvaddr=0x3002, sram_en=0, no stall. sh addr 0x3001 → ades=1, sram_wen=0.
- RD_LAT=4, lw accepted at T, flush at T+2 → stall=0 at T+2, no resp_valid through T+5, IDLE at T+3 and accepts new request.
- Store with req_valid=1 held while rst=1 → sram_en=0, sram_wen=0. rst asserted in WAIT → IDLE next cycle, stall=0, no resp_valid.
